// File: rtl/modular_mult.sv
// Sequential modular multiplier Z = (A*B) mod N: B is reduced mod N, then radix-4 MSB-first interleaved multiply over A.
// Optional build macro MODULAR_MULT_ERR_EN adds a registered err output flagging a zero modulus.
module modular_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] Z,
`ifdef MODULAR_MULT_ERR_EN
  output logic             err,
`endif
  output logic             done
);

  // Handshake: start is a level request sampled only in IDLE or DONE; a sampled start
  // latches A/B/N and drops done. done rises with Z valid and holds until the next launch.

  localparam int DW = WIDTH / 2;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DW - 1);
  localparam logic [CW-1:0] MULT_END   = CW'(DW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_MULT,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] p_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH+2:0] n1, n2, n3, n4, n5, n6;
  logic [WIDTH+1:0] red_t;
  logic [WIDTH+1:0] red_sub;
  logic [WIDTH+2:0] bm1, bm2, bm3;
  logic [WIDTH+2:0] dbm;
  logic [WIDTH+2:0] mul_t;
  logic [WIDTH+2:0] mul_sub;
  logic             launch;

  assign launch = ((state == ST_IDLE) || (state == ST_DONE)) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_REDUCE;
      ST_REDUCE: if (cnt == LAST_DIGIT) state_next = ST_MULT;
      ST_MULT:   if (cnt == MULT_END) state_next = ST_DONE;
      ST_DONE:   if (start) state_next = ST_REDUCE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Multiples of N shared by both phases; 6N still fits in WIDTH+3 bits.
  always_comb begin
    n1 = {3'b000, n_q};
    n2 = n1 << 1;
    n3 = n2 + n1;
    n4 = n1 << 2;
    n5 = n4 + n1;
    n6 = n4 + n2;
  end

  // Reduction step: R < N so T = 4R + digit < 4N and k never exceeds 3.
  always_comb begin
    red_t = {r_q, 2'b00} + {{WIDTH{1'b0}}, b_q[WIDTH-1 -: 2]};
    if (red_t >= n3[WIDTH+1:0]) begin
      red_sub = red_t - n3[WIDTH+1:0];
    end else if (red_t >= n2[WIDTH+1:0]) begin
      red_sub = red_t - n2[WIDTH+1:0];
    end else if (red_t >= n1[WIDTH+1:0]) begin
      red_sub = red_t - n1[WIDTH+1:0];
    end else begin
      red_sub = red_t;
    end
  end

  // Multiply step: P < N and d*Bm <= 3(N-1), so T < 7N and k never exceeds 6.
  always_comb begin
    bm1 = {3'b000, r_q};
    bm2 = bm1 << 1;
    bm3 = bm2 + bm1;
    case (a_q[WIDTH-1 -: 2])
      2'd1:    dbm = bm1;
      2'd2:    dbm = bm2;
      2'd3:    dbm = bm3;
      default: dbm = '0;
    endcase
    mul_t = {1'b0, p_q, 2'b00} + dbm;
    if (mul_t >= n6) begin
      mul_sub = mul_t - n6;
    end else if (mul_t >= n5) begin
      mul_sub = mul_t - n5;
    end else if (mul_t >= n4) begin
      mul_sub = mul_t - n4;
    end else if (mul_t >= n3) begin
      mul_sub = mul_t - n3;
    end else if (mul_t >= n2) begin
      mul_sub = mul_t - n2;
    end else if (mul_t >= n1) begin
      mul_sub = mul_t - n1;
    end else begin
      mul_sub = mul_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      n_q  <= '0;
      r_q  <= '0;
      p_q  <= '0;
      cnt  <= '0;
      Z    <= '0;
      done <= 1'b0;
`ifdef MODULAR_MULT_ERR_EN
      err  <= 1'b0;
`endif
    end else begin
      if (launch) begin
        a_q  <= A;
        b_q  <= B;
        n_q  <= N;
        r_q  <= '0;
        p_q  <= '0;
        cnt  <= '0;
        done <= 1'b0;
`ifdef MODULAR_MULT_ERR_EN
        err  <= 1'b0;
`endif
      end else if (state == ST_REDUCE) begin
        r_q <= red_sub[WIDTH-1:0];
        b_q <= b_q << 2;
        cnt <= (cnt == LAST_DIGIT) ? '0 : cnt + 1'b1;
      end else if (state == ST_MULT) begin
        // Final MULT cycle only publishes; a zero modulus leaves garbage in P, so force 0.
        if (cnt == MULT_END) begin
          Z    <= (n_q == '0) ? '0 : p_q;
          done <= 1'b1;
`ifdef MODULAR_MULT_ERR_EN
          err  <= (n_q == '0);
`endif
        end else begin
          p_q <= mul_sub[WIDTH-1:0];
          a_q <= a_q << 2;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_modular_mult.sv
// Directed bench for modular_mult (WIDTH=32): result values, 33-edge latency, held start,
// mid-operation disturbances and asynchronous reset.
module tb_modular_mult;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [WIDTH-1:0] N = '0;
  logic [WIDTH-1:0] Z;
  logic             done;
`ifdef MODULAR_MULT_ERR_EN
  logic             err;
`endif

  int checks   = 0;
  int failures = 0;

  modular_mult #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .N     (N),
    .Z     (Z),
`ifdef MODULAR_MULT_ERR_EN
    .err   (err),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive operands on a falling edge; returns #1 after the launch edge with start still as 'hold'.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] n, input logic hold);
    @(negedge clk);
    A = a;
    B = b;
    N = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = hold;
  endtask

  // Counts rising edges until done is seen; bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < LAT + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_case(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] exp,
                          input string tag);
    int lat;
    launch(a, b, n, 1'b0);
    check({tag, "_done_low"}, {31'b0, done}, 32'd0);
    wait_done(lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_z"}, Z, exp);
`ifdef MODULAR_MULT_ERR_EN
    check({tag, "_err"}, {31'b0, err}, (n == '0) ? 32'd1 : 32'd0);
`endif
  endtask

  initial begin
    int lat;

    #1;
    check("reset_z", Z, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done", {31'b0, done}, 32'd0);

    run_case(32'd57, 32'd18, 32'd9, 32'd0, "c57");
    run_case(32'd350, 32'd27, 32'd19, 32'd7, "c350");
    run_case(32'd54, 32'd33, 32'd68, 32'd14, "c54");
    run_case(32'd43, 32'd66, 32'd9, 32'd3, "c43");
    run_case(32'd100, 32'd200, 32'd997, 32'd60, "c100");
    run_case(32'd7775, 32'd714, 32'd779, 32'd196, "big1");
    run_case(32'd4535, 32'd4518, 32'd459, 32'd288, "big2");
    run_case(32'd3115, 32'd2117, 32'd911, 32'd637, "big3");
    run_case(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "max_nmax");
    run_case(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, "max_nm1");
    run_case(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, "n_zero");
    run_case(32'd12345, 32'd678, 32'd1, 32'd0, "n_one");

    // Done holds in DONE while start stays low
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", {31'b0, done}, 32'd1);

    // Held start: operands change while busy, relaunch in DONE picks up the new operands
    launch(32'd350, 32'd27, 32'd19, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    A = 32'd54;
    B = 32'd33;
    N = 32'd68;
    lat = 5;
    while (done !== 1'b1 && lat < LAT + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held_latency", lat, LAT);
    check("held_first_z", Z, 32'd7);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held_rerun_done_low", {31'b0, done}, 32'd0);
    check("held_rerun_z_hold", Z, 32'd7);
    wait_done(lat);
    check("held_rerun_latency", lat, LAT);
    check("held_rerun_z", Z, 32'd14);

    // Disturbances during MULT: start toggled and operands scrambled
    launch(32'd7775, 32'd714, 32'd779, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    A = $urandom_range(1, 32'hFFFF);
    B = $urandom_range(1, 32'hFFFF);
    N = $urandom_range(1, 32'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    lat = 24;
    while (done !== 1'b1 && lat < LAT + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("disturb_latency", lat, LAT);
    check("disturb_z", Z, 32'd196);

    // Asynchronous reset in the middle of REDUCE
    launch(32'd3115, 32'd2117, 32'd911, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_z", Z, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    check("post_rst_idle_done", {31'b0, done}, 32'd0);
    check("post_rst_idle_z", Z, 32'd0);
    run_case(32'd43, 32'd66, 32'd9, 32'd3, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
